// File: rtl/seq_shifter_pkg.sv
// Shared ALU shift definitions: mode encodings used by every shift block
// and the ALU decoder, plus the sequential shifter's FSM state type.
package seq_shifter_pkg;

    // Shift mode encodings (shared with the combinational shifters and decoder)
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Sequential shifter control states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One combinational shift step of 0..STEP bits in any of the four modes.
// The carry is the last bit that left the word during this step and is
// zero when no shift takes place.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    // One extra bit on the exit side of each shifter captures the carry
    logic [WIDTH:0]   lsl_s;
    logic [WIDTH:0]   lsr_s;
    logic [WIDTH:0]   asr_s;
    logic [WIDTH-1:0] ror_s;

    assign lsl_s = {1'b0, data} << k;
    assign lsr_s = {data, 1'b0} >> k;
    // The MSB of the working value is never altered by ASR, so it still
    // equals the original operand's sign bit on every step.
    assign asr_s = $signed({data, 1'b0}) >>> k;
    // Rotation as a shift of the doubled word, keeping the low half
    assign ror_s = WIDTH'({data, data} >> k);

    // Select the result and carry for the requested mode
    always_comb begin
        res   = data;
        carry = 1'b0;
        case (mode)
            SHIFT_LSL: begin
                res   = lsl_s[WIDTH-1:0];
                carry = lsl_s[WIDTH];
            end
            SHIFT_LSR: begin
                res   = lsr_s[WIDTH:1];
                carry = lsr_s[0];
            end
            SHIFT_ASR: begin
                res   = asr_s[WIDTH:1];
                carry = asr_s[0];
            end
            SHIFT_ROR: begin
                res = ror_s;
                // The last rotated bit lands in the MSB; nothing moves for k = 0
                if (k != {KW{1'b0}}) begin
                    carry = ror_s[WIDTH-1];
                end else begin
                    carry = 1'b0;
                end
            end
            default: begin
                res   = data;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: accepts one operation over valid/ready, shifts
// by up to STEP bits per cycle, then presents the result and carry until
// the consumer takes it.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    localparam int KW = $clog2(STEP + 1);
    // STEP in a width able to hold WIDTH itself, for the min() compare
    localparam logic [SHW:0]   STEP_W = (SHW + 1)'(STEP);
    // STEP in counter width; only used when remaining >= STEP, which
    // cannot happen for STEP = WIDTH, so truncation there is harmless
    localparam logic [SHW-1:0] STEP_N = SHW'(STEP);

    state_t           state_r;
    state_t           state_n;
    logic [WIDTH-1:0] data_r;
    logic [1:0]       mode_r;
    logic [SHW-1:0]   rem_r;
    logic             carry_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             accept_s;
    logic [SHW-1:0]   k_sel_s;
    logic [SHW-1:0]   rem_left_s;
    logic [KW-1:0]    k_s;
    logic [WIDTH-1:0] step_res_s;
    logic             step_carry_s;

    assign accept_s  = (state_r == IDLE) && in_valid && in_ready_r;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = data_r;
    assign out_carry = carry_r;

    // Step size this cycle: k = min(STEP, remaining), and what is left after it
    always_comb begin
        k_sel_s = rem_r;
        if ({1'b0, rem_r} >= STEP_W) begin
            k_sel_s = STEP_N;
        end else begin
            k_sel_s = rem_r;
        end
        rem_left_s = rem_r - k_sel_s;
        k_s        = KW'(k_sel_s);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data  (data_r),
        .k     (k_s),
        .mode  (mode_r),
        .res   (step_res_s),
        .carry (step_carry_s)
    );

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (in_shamt == {SHW{1'b0}}) begin
                        state_n = DONE;
                    end else begin
                        state_n = SHIFT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (rem_left_s == {SHW{1'b0}}) begin
                    state_n = DONE;
                end else begin
                    state_n = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
        end
    end

    // Datapath: capture on accept, step while shifting, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            mode_r  <= 2'b00;
            rem_r   <= {SHW{1'b0}};
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        data_r  <= in_data;
                        mode_r  <= in_mode;
                        rem_r   <= in_shamt;
                        carry_r <= 1'b0;
                    end else begin
                        data_r  <= data_r;
                        mode_r  <= mode_r;
                        rem_r   <= rem_r;
                        carry_r <= carry_r;
                    end
                end
                SHIFT: begin
                    data_r  <= step_res_s;
                    carry_r <= step_carry_s;
                    rem_r   <= rem_left_s;
                end
                DONE: begin
                    // Result is held until the consumer accepts it
                    data_r  <= data_r;
                    carry_r <= carry_r;
                end
                default: begin
                    data_r  <= {WIDTH{1'b0}};
                    mode_r  <= 2'b00;
                    rem_r   <= {SHW{1'b0}};
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: five instances (STEP 1, 2, 4, 8, 32) driven one at
// a time; expected results are queued at request time and compared when
// the result handshake happens.
module tb_seq_shifter;

    localparam int NI = 5;
    localparam logic [4:0][7:0] STEPS = {8'd32, 8'd8, 8'd4, 8'd2, 8'd1};

    logic                  clk;
    logic                  rst_n;
    logic [NI-1:0]         in_valid;
    logic [NI-1:0]         in_ready;
    logic [NI-1:0][31:0]   in_data;
    logic [NI-1:0][4:0]    in_shamt;
    logic [NI-1:0][1:0]    in_mode;
    logic [NI-1:0]         out_valid;
    logic [NI-1:0]         out_ready;
    logic [NI-1:0][31:0]   out_data;
    logic [NI-1:0]         out_carry;

    int n_tests;
    int n_fail;
    logic [32:0] sb[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_shifter #(
            .WIDTH (32),
            .STEP  (int'(STEPS[g]))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_shamt  (in_shamt[g]),
            .in_mode   (in_mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_carry (out_carry[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: shift one bit at a time, remembering the last bit to leave
    function automatic logic [32:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] m);
        logic [31:0] v;
        logic        c;
        logic        msb;
        v   = d;
        c   = 1'b0;
        msb = d[31];
        for (int j = 0; j < sh; j++) begin
            case (m)
                2'b00:   begin c = v[31]; v = {v[30:0], 1'b0}; end
                2'b01:   begin c = v[0];  v = {1'b0, v[31:1]}; end
                2'b10:   begin c = v[0];  v = {msb, v[31:1]};  end
                default: begin c = v[0];  v = {v[0], v[31:1]}; end
            endcase
        end
        return {c, v};
    endfunction

    task automatic check_reset_vals(input int i, input string tg);
        check({tg, "_in_ready"},  64'(in_ready[i]),  64'd1);
        check({tg, "_out_valid"}, 64'(out_valid[i]), 64'd0);
        check({tg, "_out_data"},  64'(out_data[i]),  64'd0);
        check({tg, "_out_carry"}, 64'(out_carry[i]), 64'd0);
    endtask

    // One complete operation on instance i, with 'hold' cycles of back-pressure
    task automatic do_op(input int i, input logic [31:0] d, input logic [4:0] sh,
                         input logic [1:0] m, input int hold);
        int          n;
        int          lat;
        int          st;
        int          exp_lat;
        logic [32:0] e;
        string       tg;
        st = int'(STEPS[i]);
        tg = $sformatf("s%0d_m%0d_sh%0d", st, m, sh);
        in_data[i]  = d;
        in_shamt[i] = sh;
        in_mode[i]  = m;
        in_valid[i] = 1'b1;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[i]) begin
            check({tg, "_ready_timeout"}, 64'(in_ready[i]), 64'd1);
            in_valid[i] = 1'b0;
            return;
        end
        sb.push_back(ref_shift(d, int'(sh), m));
        @(posedge clk); #1;
        // Scramble the request lines so late sampling would be visible
        in_valid[i] = 1'b0;
        in_data[i]  = ~d;
        in_shamt[i] = ~sh;
        in_mode[i]  = ~m;
        lat = 1;
        while (!out_valid[i] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = 1 + (int'(sh) + st - 1) / st;
        check({tg, "_latency"}, 64'(lat), 64'(exp_lat));
        e = sb.pop_front();
        if (!out_valid[i]) begin
            return;
        end
        for (int h = 0; h < hold; h++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = $urandom;
            in_shamt[i] = 5'($urandom_range(1, 31));
            @(posedge clk); #1;
            check({tg, "_bp_valid"}, 64'(out_valid[i]), 64'd1);
            check({tg, "_bp_ready"}, 64'(in_ready[i]),  64'd0);
            check({tg, "_bp_data"},  64'(out_data[i]),  64'(e[31:0]));
        end
        in_valid[i] = 1'b0;
        check({tg, "_data"},  64'(out_data[i]),  64'(e[31:0]));
        check({tg, "_carry"}, 64'(out_carry[i]), 64'(e[32]));
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
        check({tg, "_idle_ready"}, 64'(in_ready[i]),  64'd1);
        check({tg, "_idle_valid"}, 64'(out_valid[i]), 64'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = '0;
        #12;
        for (int i = 0; i < NI; i++) check_reset_vals(i, $sformatf("rst_s%0d", int'(STEPS[i])));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases on STEP = 1
        do_op(0, 32'h0000_0006, 5'd2, 2'b01, 0);
        do_op(0, 32'h8000_0000, 5'd4, 2'b10, 0);
        do_op(0, 32'h8000_0001, 5'd1, 2'b00, 0);
        do_op(0, 32'h0000_0001, 5'd1, 2'b11, 0);
        do_op(0, 32'h1234_5678, 5'd3, 2'b11, 5);
        // Directed cases on STEP = 4
        do_op(2, 32'hFFFF_FFFF, 5'd31, 2'b01, 0);
        do_op(2, 32'h0000_000A, 5'd0,  2'b01, 0);

        // Boundary shifts and random sweep on every instance
        for (int i = 0; i < NI; i++) begin
            for (int m = 0; m < 4; m++) begin
                do_op(i, 32'h9E37_79B9, 5'd31, 2'(m), 0);
                do_op(i, 32'hC001_0003, 5'd0,  2'(m), 0);
            end
            for (int t = 0; t < 30; t++) begin
                do_op(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)));
            end
        end

        // Asynchronous reset in the middle of a STEP = 1 shift
        in_data[0]  = 32'd10;
        in_shamt[0] = 5'd10;
        in_mode[0]  = 2'b01;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals(0, "midrst");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 32'd10, 5'd6, 2'b01, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised multi-cycle shift unit for the ALU, the successor to the combinational logical-shift-right block. It supports four modes: LSL, LSR, ASR and ROR, all at configurable width. Each cycle it shifts by up to STEP bits, trading latency for area. It accepts one operation at a time over a valid/ready handshake, returns the result and a carry-out (the last bit shifted out), and holds the result until the consumer accepts it.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, ≥ 4.
STEP, 1, max bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
(derived localparam SHW = $clog2(WIDTH), shift-amount width)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_data  input  WIDTH  operand
in_shamt  input  SHW  shift amount, 0..WIDTH-1
in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
out_carry  output  1  last bit shifted out; 0 when shamt = 0

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_carry = 0, internal counter = 0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture in_data, in_shamt and in_mode.
  - out_carry is cleared on capture.
  - If in_shamt = 0, go to DONE; otherwise go to SHIFT with remaining = in_shamt.
- SHIFT:
  - in_ready = 0; out_valid = 0.
  - Each cycle, shift by k = min(STEP, remaining) and set remaining -= k.
  - Go to DONE when remaining reaches 0 after the update.
  - SHIFT lasts ceil(shamt/STEP) cycles.
- DONE:
  - out_valid = 1; out_data and out_carry are stable.
  - On out_ready, go to IDLE. in_ready rises in the following cycle, so there is one idle cycle between operations.
  - Back-pressure (out_ready = 0) holds DONE indefinitely with outputs unchanged.
- Latency from accept to out_valid:
  - 1 cycle for shamt = 0.
  - 1 + ceil(shamt/STEP) cycles otherwise.
- Per-step shift semantics (k bits):
  - LSL: zeros enter at the LSB; carry = bit WIDTH-k before the step.
  - LSR: zeros enter at the MSB; carry = bit k-1 before the step.
  - ASR: copies of the original MSB enter at the MSB; carry = bit k-1.
  - ROR: bits leave the LSB and re-enter at the MSB; carry = new bit WIDTH-1 (the last bit rotated).
- Width rules:
  - in_shamt is naturally bounded to WIDTH-1 by its width; no saturation logic is needed.
  - Result widths are exact; there is no overflow flag.
- Handshake rules:
  - in_valid while busy is ignored; the producer must hold the request until in_ready.
  - in_data must not be sampled outside the IDLE accept cycle.
- Reset mid-operation (SHIFT or DONE): the block returns immediately to reset values; the in-flight result is discarded.
- The unconsumed result is overwritten only after the out_valid & out_ready handshake.

Decomposition:
- Shared ALU package holds:
  - Mode encoding constants SHIFT_LSL = 2'b00, SHIFT_LSR = 2'b01, SHIFT_ASR = 2'b10, SHIFT_ROR = 2'b11 (also used by the existing shift blocks and the ALU decoder).
  - FSM state typedef (IDLE/SHIFT/DONE).
- One natural sub-module: shift_step.
  - Combinational; parametrised by WIDTH and STEP.
  - Takes data, k (0..STEP) and mode; returns shifted data and carry.
  - Instantiated once, driving the datapath register in seq_shifter.

Test Plan:
1. WIDTH = 32, STEP = 1; LSR in_data = 6, shamt = 2 -> out_data = 1, out_carry = 1, out_valid 3 cycles after accept.
2. ASR in_data = 0x80000000, shamt = 4 -> 0xF8000000, carry 0; then LSL 0x80000001, shamt = 1 -> 0x00000002, carry 1; then ROR 0x00000001, shamt = 1 -> 0x80000000, carry 1.
3. STEP = 4; LSR in_data = 0xFFFFFFFF, shamt = 31 -> 0x00000001, carry 1, latency 1 + 8 = 9 cycles; shamt = 0 on in_data = 10 -> 10, carry 0, latency 1.
4. Back-pressure: hold out_ready = 0 for 5 cycles in DONE -> out_valid/out_data stable, in_ready = 0, new in_valid ignored; release -> in_ready = 1 the next cycle.
5. Reset mid-op: assert rst_n = 0 asynchronously during SHIFT of LSR 10 by 10 -> outputs drop to reset values without waiting for a clock; after release, LSR 10 by 6 -> 0, carry 0.
6. Randomised-mode sweep against a reference model (all modes, shamt 0..31) for STEP ∈ {1, 2, 8, 32}, plus back-to-back requests -> exact match and one idle cycle between operations.
